key_debouncer: RTL

- Conditions one raw push-button input into clean, single-cycle control events for the event counter and its reset logic.
- Sits directly upstream of the event counter; one instance per KEY.
- Performs a 2-FF synchronisation, then counter-based debounce, then press/release edge detection, with optional hold-to-auto-repeat.
- All outputs are registered and synchronous to CLOCK_50.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_debouncer_if.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/key_debouncer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and the
// clock-rate constants used to derive the default timing parameters.
package key_pkg;

    // Button FSM: released, held (waiting for first repeat), auto-repeating.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    localparam int CLK_HZ        = 50000000;
    localparam int CYCLES_PER_MS = CLK_HZ / 1000;

    // Default timings: 10 ms debounce, 500 ms to first repeat, 100 ms repeat rate.
    localparam int DEF_DEBOUNCE_CYCLES = 10  * CYCLES_PER_MS;
    localparam int DEF_HOLD_CYCLES     = 500 * CYCLES_PER_MS;
    localparam int DEF_REPEAT_CYCLES   = 100 * CYCLES_PER_MS;

endpackage

// File: rtl/key_debouncer_if.sv
// Bundle of the raw key input and the conditioned button outputs.
// master = debouncer side, slave = consumer (event counter / reset logic).
interface key_debouncer_if;
    logic KEY_IN;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic event_pulse;

    modport master (
        input  KEY_IN,
        output pressed, press_pulse, release_pulse, repeat_pulse, event_pulse
    );

    modport slave (
        output KEY_IN,
        input  pressed, press_pulse, release_pulse, repeat_pulse, event_pulse
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset
// value so the synchronised level comes out of reset in a known state.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Capture the raw input, then re-register to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/key_debouncer.sv
// Push-button conditioner: synchronise, debounce with a run-length counter,
// then turn the clean level into press / release / auto-repeat strobes.
module key_debouncer
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    key_debouncer_if.master bus
);
    localparam logic [0:0] RELEASED_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    logic [0:0]        w_sync;
    logic              w_sample;
    logic              w_differ;
    logic              w_toggle;
    logic              w_rise;
    logic              w_fall;

    logic [DB_W-1:0]   r_db_cnt;
    logic              r_stable;
    key_state_t        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_repeat_pulse;
    logic              r_event_pulse;

    // Sync FFs come out of reset at the released level, so a key held through
    // reset still has to be debounced as a fresh press.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (RELEASED_LVL)
    ) u_sync (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .i_d   (bus.KEY_IN),
        .o_q   (w_sync)
    );

    // Normalise polarity: 1 always means pressed from here on.
    assign w_sample = w_sync[0] ^ RELEASED_LVL[0];
    assign w_differ = (w_sample != r_stable);
    assign w_toggle = w_differ && (r_db_cnt == DB_LAST);
    assign w_rise   = w_toggle && !r_stable;
    assign w_fall   = w_toggle &&  r_stable;

    // Debounce: count consecutive disagreeing samples, accept on the last one.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else if (!w_differ) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_stable <= ~r_stable;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Button FSM with registered strobes; a release always beats a due repeat.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state         <= IDLE;
            r_hold_cnt      <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            r_event_pulse   <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            r_event_pulse   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state       <= HELD;
                        r_hold_cnt    <= '0;
                        r_press_pulse <= 1'b1;
                        r_event_pulse <= 1'b1;
                    end
                end
                HELD: begin
                    if (w_fall) begin
                        r_state         <= IDLE;
                        r_hold_cnt      <= '0;
                        r_release_pulse <= 1'b1;
                    end else if ((REPEAT_EN != 0) && (r_hold_cnt == HOLD_LAST)) begin
                        r_state        <= REPEAT;
                        r_hold_cnt     <= '0;
                        r_repeat_pulse <= 1'b1;
                        r_event_pulse  <= 1'b1;
                    end else if (REPEAT_EN != 0) begin
                        // Without auto-repeat the counter has nothing to time.
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (w_fall) begin
                        r_state         <= IDLE;
                        r_hold_cnt      <= '0;
                        r_release_pulse <= 1'b1;
                    end else if (r_hold_cnt == REP_LAST) begin
                        r_hold_cnt     <= '0;
                        r_repeat_pulse <= 1'b1;
                        r_event_pulse  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.pressed       = r_stable;
    assign bus.press_pulse   = r_press_pulse;
    assign bus.release_pulse = r_release_pulse;
    assign bus.repeat_pulse  = (REPEAT_EN != 0) ? r_repeat_pulse : 1'b0;
    assign bus.event_pulse   = r_event_pulse;
endmodule
